// File: rtl/lsd_norm_if.sv
// Handshake bundle for lsd_normalizer: operand in (valid/ready), result out (valid/ready).
// The zero flag exists only when LSD_NORM_ZERO_FLAG_EN is defined.
`timescale 1ns/1ps
interface lsd_norm_if #(
   parameter int WIDTH = 16
);
   localparam int SW = $clog2(WIDTH);

   logic                    in_valid;
   logic                    in_ready;
   logic signed [WIDTH-1:0] a;
   logic                    out_valid;
   logic                    out_ready;
   logic signed [WIDTH-1:0] norm;
   logic [SW-1:0]           shift;
`ifdef LSD_NORM_ZERO_FLAG_EN
   logic                    zero;
`endif

   // producer/consumer side
   modport master (
      output in_valid, a, out_ready,
      input  in_ready, out_valid, norm, shift
`ifdef LSD_NORM_ZERO_FLAG_EN
      , input zero
`endif
   );

   // normalizer side
   modport slave (
      input  in_valid, a, out_ready,
      output in_ready, out_valid, norm, shift
`ifdef LSD_NORM_ZERO_FLAG_EN
      , output zero
`endif
   );
endinterface

// File: rtl/lsd_normalizer.sv
// Two-stage normalizer for signed operands: leading-sign detection on capture,
// encode + left shift in the second stage. SPEED picks the prefix-OR structure of
// the detector (0 serial, 1 Brent-Kung, 2 Sklansky); all three are functionally equal.
// Optional zero flag output: define LSD_NORM_ZERO_FLAG_EN.
`timescale 1ns/1ps
module lsd_normalizer #(
   parameter int WIDTH = 16,
   parameter int SPEED = 0
) (
   input  logic     clk,
   input  logic     rst,
   lsd_norm_if.slave bus
);
   localparam int SW = $clog2(WIDTH);
   localparam int N  = WIDTH - 1;
   localparam int LG = (N > 1) ? $clog2(N) : 1;

   logic                    s2_load;
   logic                    accept;
   logic [WIDTH-1:0]        z_p0;
   logic                    vld_p1;
   logic signed [WIDTH-1:0] a_p1;
   logic [WIDTH-1:0]        z_p1;
   logic signed [WIDTH-1:0] norm_c;
   logic [SW-1:0]           shift_c;
   logic                    zero_c;
   logic                    vld_p2;
   logic signed [WIDTH-1:0] norm_p2;
   logic [SW-1:0]           shift_p2;

   // One-hot Z to left-shift count; a zero vector means all-sign and gives WIDTH-1.
   function automatic logic [SW-1:0] lsd_shift(input logic [WIDTH-1:0] z);
      logic [SW-1:0] s;
      s = SW'(WIDTH - 1);
      for (int k = 0; k < WIDTH - 1; k++)
         if (z[k]) s = SW'(WIDTH - 2 - k);
      return s;
   endfunction

   assign s2_load      = ~vld_p2 | bus.out_ready;
   assign bus.in_ready = ~vld_p1 | s2_load;
   assign accept       = bus.in_valid & bus.in_ready;

   // Leading-sign detector: d_r is the sign-difference vector scanned from just
   // below the sign bit downwards; q is its inclusive prefix OR, so the first set
   // bit of d_r is the one with no set bit above it.
   always_comb begin
      logic [N-1:0] d_r;
      logic [N-1:0] q;
      for (int j = 0; j < N; j++) d_r[j] = bus.a[N-1-j] ^ bus.a[WIDTH-1];
      q = d_r;
      if (SPEED == 0) begin
         for (int j = 1; j < N; j++) q[j] = q[j] | q[j-1];
      end else if (SPEED == 1) begin
         for (int l = 0; l < LG; l++)
            for (int j = 0; j < N; j++)
               if (((j + 1) % (2 << l)) == 0) q[j] = q[j] | q[j - (1 << l)];
         for (int l = LG - 1; l >= 0; l--)
            for (int j = 0; j < N; j++)
               if ((((j + 1) % (2 << l)) == (1 << l)) && ((j + 1) > (2 << l)))
                  q[j] = q[j] | q[j - (1 << l)];
      end else begin
         for (int l = 0; l < LG; l++)
            for (int j = 0; j < N; j++)
               if (((j >> l) & 1) == 1) q[j] = q[j] | q[((j >> l) << l) - 1];
      end
      z_p0      = '0;
      z_p0[N-1] = d_r[0];
      for (int j = 1; j < N; j++) z_p0[N-1-j] = d_r[j] & ~q[j-1];
   end

   // Encode and shift; an all-sign operand passes through unshifted.
   always_comb begin
      shift_c = lsd_shift(z_p1);
      zero_c  = ~|z_p1;
      norm_c  = zero_c ? a_p1 : (a_p1 << shift_c);
   end

   // ---- stage 1: capture operand and its LSD vector
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         vld_p1 <= 1'b0;
         a_p1   <= '0;
         z_p1   <= '0;
      end else begin
         if (bus.in_ready) vld_p1 <= bus.in_valid;
         if (accept) begin
            a_p1 <= bus.a;
            z_p1 <= z_p0;
         end
      end
   end

   // ---- stage 2: registered result, held while the consumer stalls
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         vld_p2   <= 1'b0;
         norm_p2  <= '0;
         shift_p2 <= '0;
      end else if (s2_load) begin
         vld_p2 <= vld_p1;
         if (vld_p1) begin
            norm_p2  <= norm_c;
            shift_p2 <= shift_c;
         end
      end
   end

`ifdef LSD_NORM_ZERO_FLAG_EN
   logic zero_p2;

   // Zero flag travels with the stage-2 result.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)                   zero_p2 <= 1'b0;
      else if (s2_load & vld_p1) zero_p2 <= zero_c;
   end

   assign bus.zero = zero_p2;
`endif

   assign bus.out_valid = vld_p2;
   assign bus.norm      = norm_p2;
   assign bus.shift     = shift_p2;
endmodule
